note_scheduler: RTL

NOTE_SCHEDULER -- requirements
Module: note_scheduler

---
 rtl/note_scheduler_if.sv | 31 +++
 rtl/note_scheduler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/note_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : note_scheduler_if                                            |
// | Description : Game-side signal bundle between the note scheduler and its  |
// |               button, LFSR and score peers.                               |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface note_scheduler_if;
  logic       start;
  logic [3:0] buttons;
  logic [1:0] lane_rand;
  logic       rand_adv;
  logic [1:0] lane;
  logic       note_valid;
  logic       score_inc;
  logic       score_dec;
  logic [6:0] notes_played;
  logic [3:0] streak;
  logic       done;

  modport master (
    output start, buttons, lane_rand,
    input  rand_adv, lane, note_valid, score_inc, score_dec, notes_played, streak, done
  );

  modport slave (
    input  start, buttons, lane_rand,
    output rand_adv, lane, note_valid, score_inc, score_dec, notes_played, streak, done
  );
endinterface
`default_nettype wire

// File: rtl/note_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : note_scheduler                                               |
// | Description : Rhythm-game note sequencer: opens a hit window per note,    |
// |               judges lane presses, paces rests. Optional streak/bonus     |
// |               logic is enabled by defining RHYTHM_STREAK_EN.              |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module note_scheduler #(
  parameter int WINDOW   = 50000000,
  parameter int GAP      = 25000000,
  parameter int SONG_LEN = 127
) (
  input  logic            clk,
  input  logic            rst,
  note_scheduler_if.slave bus
);
  localparam int               c_CNT_MAX  = (WINDOW > GAP) ? WINDOW : GAP;
  localparam int               c_CW       = $clog2(c_CNT_MAX);
  localparam logic [c_CW-1:0]  c_WIN_LOAD = c_CW'(WINDOW - 1);
  localparam logic [c_CW-1:0]  c_GAP_LOAD = c_CW'(GAP - 1);
  localparam logic [c_CW-1:0]  c_CNT_ONE  = c_CW'(1);
  localparam logic [6:0]       c_SONG_LEN = 7'(SONG_LEN);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WIN  = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t          r_state;
  logic [3:0]      r_sync1;
  logic [3:0]      r_sync2;
  logic [3:0]      r_prev;
  logic [c_CW-1:0] r_cnt;
  logic [1:0]      r_lane;
  logic            r_rand_adv;
  logic            r_note_valid;
  logic            r_score_inc;
  logic            r_score_dec;
  logic [6:0]      r_notes;
  logic            r_done;

  logic [3:0]      w_edges;
  logic            w_hit;
  logic            w_judge;
  logic            w_judge_hit;
  logic            w_bonus;

  // Buttons are active-low; the third stage remembers the last synced value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
      r_prev  <= 4'hF;
    end else begin
      r_sync1 <= bus.buttons;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_edges     = r_prev & ~r_sync2;
  assign w_hit       = (w_edges == (4'b0001 << r_lane));
  // A press wins over the timeout when both land in the same cycle.
  assign w_judge     = (r_state == ST_WIN) && ((w_edges != 4'h0) || (r_cnt == '0));
  assign w_judge_hit = (r_state == ST_WIN) && w_hit;

`ifdef RHYTHM_STREAK_EN
  logic [3:0] r_streak;
  logic       r_bonus;
  logic [3:0] w_streak_next;

  assign w_streak_next = (r_streak == 4'd15) ? r_streak : r_streak + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_streak <= 4'd0;
      r_bonus  <= 1'b0;
    end else begin
      r_bonus <= 1'b0;
      if (w_judge) begin
        if (w_judge_hit) begin
          r_streak <= w_streak_next;
          r_bonus  <= (r_streak != 4'd15) && (w_streak_next[1:0] == 2'b00);
        end else begin
          r_streak <= 4'd0;
        end
      end
    end
  end

  assign w_bonus    = r_bonus;
  assign bus.streak = r_streak;
`else
  assign w_bonus    = 1'b0;
  assign bus.streak = 4'd0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_lane       <= 2'd0;
      r_rand_adv   <= 1'b0;
      r_note_valid <= 1'b0;
      r_score_inc  <= 1'b0;
      r_score_dec  <= 1'b0;
      r_notes      <= 7'd0;
      r_done       <= 1'b0;
    end else begin
      r_rand_adv  <= 1'b0;
      r_score_inc <= w_bonus;
      r_score_dec <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state    <= ST_LOAD;
            r_rand_adv <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_lane       <= bus.lane_rand;
          r_cnt        <= c_WIN_LOAD;
          r_note_valid <= 1'b1;
          r_state      <= ST_WIN;
        end
        ST_WIN: begin
          if (w_judge) begin
            r_score_inc  <= w_hit;
            r_score_dec  <= ~w_hit;
            r_note_valid <= 1'b0;
            r_cnt        <= c_GAP_LOAD;
            if (r_notes != 7'h7F) begin
              r_notes <= r_notes + 7'd1;
            end
            r_state <= ST_GAP;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        ST_GAP: begin
          if (r_cnt == '0) begin
            if (r_notes == c_SONG_LEN) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= ST_LOAD;
              r_rand_adv <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rand_adv     = r_rand_adv;
  assign bus.lane         = r_lane;
  assign bus.note_valid   = r_note_valid;
  assign bus.score_inc    = r_score_inc;
  assign bus.score_dec    = r_score_dec;
  assign bus.notes_played = r_notes;
  assign bus.done         = r_done;
endmodule
`default_nettype wire
